// File: rtl/dvs_event_assembler.sv
// dvs_event_assembler: pairs AER X words with the latest Y row into a FWFT event FIFO.
// Optional row timestamps are enabled by defining DVS_EVT_TIMESTAMP_EN.
module dvs_event_assembler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int TS_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
`ifdef DVS_EVT_TIMESTAMP_EN
  localparam int EW = 20 + TS_W
`else
  localparam int EW = 20 + 0 * TS_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [9:0]       rx_word,
  input  logic             rx_xsel,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EW-1:0]    evt_data,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] orphan_cnt,
  output logic [LW-1:0]    fifo_level
);
  typedef enum logic {NO_ROW, ROW_VALID} row_state_t;
  row_state_t state;
  logic [9:0] row_y;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [EW-1:0] evt;
  logic is_x, is_y, pop, full, want, push, drop, orphan;
  assign is_x = rx_valid & rx_xsel;
  assign is_y = rx_valid & ~rx_xsel;
  assign evt_valid = fifo_level != '0;
  assign pop = evt_valid & evt_ready;
  assign full = fifo_level == LW'(DEPTH);
  assign want = is_x & (state == ROW_VALID);
  // a full FIFO still takes the push when the head leaves in the same cycle
  assign push = want & (~full | pop);
  assign drop = want & full & ~pop;
  assign orphan = is_x & (state == NO_ROW);
  assign evt_data = evt_valid ? mem[rd_ptr] : '0;
`ifdef DVS_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt, row_ts;
  assign evt = {row_ts, row_y, rx_word};
  always_ff @(posedge clk)
    if (!rst_n) begin
      ts_cnt <= '0;
      row_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (is_y) row_ts <= ts_cnt;
    end
`else
  assign evt = {row_y, rx_word};
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= NO_ROW;
      row_y <= '0;
    end else if (is_y) begin
      state <= ROW_VALID;
      row_y <= rx_word;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= evt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_level <= '0;
      drop_cnt <= '0;
      orphan_cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      drop_cnt <= drop_cnt + CNT_W'(drop && !(&drop_cnt));
      orphan_cnt <= orphan_cnt + CNT_W'(orphan && !(&orphan_cnt));
    end
endmodule

// File: doc/dvs_event_assembler.md
# dvs_event_assembler

Downstream of the AER receiver stage. Consumes each validated 10-bit AER word (Y row word or X column word) and pairs every X word with the most recent Y word to form a complete DVS event `{y, x, polarity}`. Completed events are buffered in a first-word-fall-through FIFO and offered to the RAVENS-side consumer over a valid/ready handshake. Orphan X words and FIFO overflow are dropped and counted.

## Interface

- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `CNT_W`, 16: width of the saturating drop and orphan counters.
- `TS_W`, 16: timestamp width; used only when `DVS_EVT_TIMESTAMP_EN` is defined.

- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_word`/`rx_xsel` hold a new AER word.
- `rx_word`  in  10  AER word.
- `rx_xsel`  in  1  1 = X word, 0 = Y word.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `evt_data`  out  EW  EW = 20, or 20+TS_W with the macro; format is given under Operation.
- `drop_cnt`  out  CNT_W  events lost to a full FIFO; saturating.
- `orphan_cnt`  out  CNT_W  X words received with no row latched; saturating.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Row FSM has two states:
  - `NO_ROW`: the reset state.
  - `ROW_VALID`.
- Y word, in any state:
  - `row_y <= rx_word[9:0]`.
  - State becomes `ROW_VALID`.
  - With the macro: `row_ts <= ts_cnt`.
  - Y words never push to the FIFO.
- X word in `ROW_VALID`:
  - Forms the event `{row_y, rx_word[9:1], rx_word[0]}`: y = 10 bits, x = 9 bits, pol = 1 bit.
  - Pushes the event to the FIFO.
  - State stays `ROW_VALID`, so one row serves any number of X words.
- X word in `NO_ROW`: discarded; `orphan_cnt` increments.
- `evt_data` bit layout (MSB first):
  - `[19:10]` y, `[9:1]` x, `[0]` pol.
  - With the macro, the row timestamp sits above bit 19.
- FIFO:
  - Circular buffer with a read pointer, a write pointer and a level counter; pointers wrap modulo DEPTH.
  - A push is accepted when `fifo_level < DEPTH`, or when `fifo_level == DEPTH` and a pop occurs in the same cycle.
  - Any other push while full is dropped; `drop_cnt` increments and FIFO contents are unchanged.
  - Pop occurs when `evt_valid && evt_ready`.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - `evt_ready` while empty has no effect.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - FSM in `NO_ROW`; `row_y` = 0.
  - `evt_valid` = 0, `fifo_level` = 0, `drop_cnt` = 0, `orphan_cnt` = 0.
  - `evt_data` = 0; `ts_cnt` = 0 with the macro.
- Reset asserted mid-stream:
  - Flushes buffered events.
  - Forgets the latched row, so the next X word is an orphan.

## Timing

- X word strobed in cycle N into an empty FIFO: `evt_valid` = 1 and `evt_data` valid in cycle N+1.
- `evt_data` is registered from the FIFO head and stays stable while `evt_valid && !evt_ready`.
- After a pop in cycle M, the next head is presented in cycle M+1; one event per cycle is sustained.
- `fifo_level` reflects pushes and pops from the previous cycle.
- Counters update in the cycle after the offending strobe.
- A Y word strobed in cycle N applies to an X word strobed in cycle N+1 or later.
- `rx_valid` may be asserted on consecutive cycles; every strobe is processed.

## Configuration

- Macro: `DVS_EVT_TIMESTAMP_EN`.
- Defined:
  - A free-running `TS_W`-bit `ts_cnt` increments every cycle and wraps to 0.
  - `ts_cnt` is latched into `row_ts` on each Y word.
  - `evt_data` is 20+TS_W bits, with `row_ts` in the MSBs.
- Undefined: there is no timestamp logic and `evt_data` is exactly 20 bits.

## Test plan

- Reset, then Y=0x155 followed by X word 0x0F3: in the next cycle `evt_valid`=1 and `evt_data`=`{0x155, 0x079, 1}`.
- After reset, strobe X=0x010 with no prior Y: no event is produced; `orphan_cnt`=1 and `fifo_level`=0.
- Y=5, then X words 1..10 with `evt_ready`=0 and DEPTH=8:
  - `fifo_level`=8 and `drop_cnt`=2.
  - Then hold `evt_ready`=1: events with x = 0..4 are popped in order (x = rx_word[9:1]).
- With the FIFO full, push and `evt_ready`=1 in the same cycle: the push is accepted, `fifo_level` stays 8 and `drop_cnt` is unchanged.
- Pulse `rst_n`=0 for one cycle while `fifo_level`=3: the next cycle shows `evt_valid`=0 and `fifo_level`=0; the following X word counts as an orphan.
- With the macro, strobe Y at `ts_cnt`=0x0100, then X twice 20 cycles apart: both events carry ts=0x0100.
